// File: rtl/norm_row_collector.sv
// norm_row_collector
//   Collects serial normalized psum pairs (core1, core2) from the normalizer
//   into rows of 2*COL elements. Core1 fills the low half of the row and core2
//   the high half. Completed rows are buffered in a small FIFO and drained
//   through a valid/ready port. The normalizer cannot be stalled, so a
//   completed row that finds the FIFO full is dropped and overflow latches.
// Ports
//   clk, reset               single clock, synchronous active-high reset
//   norm_valid               one element pair present this cycle
//   psum_norm_1/psum_norm_2  core1 / core2 element
//   clear                    discard the partial row (FIFO untouched)
//   row_out, row_valid       head-of-FIFO row (zero when empty)
//   row_ready                consumer accepts row_out
//   fill_level               rows stored, 0..DEPTH
//   overflow                 sticky: a completed row was dropped
module norm_row_collector #(
   parameter int BW_PSUM = 11,
   parameter int COL     = 8,
   parameter int DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         norm_valid,
   input  logic [BW_PSUM-1:0]           psum_norm_1,
   input  logic [BW_PSUM-1:0]           psum_norm_2,
   input  logic                         clear,
   output logic [2*COL*BW_PSUM-1:0]     row_out,
   output logic                         row_valid,
   input  logic                         row_ready,
   output logic [$clog2(DEPTH):0]       fill_level,
   output logic                         overflow
);
   localparam int ROW_W = 2*COL*BW_PSUM;
   localparam int PW    = $clog2(DEPTH);
   localparam int FW    = PW + 1;
   localparam logic [3:0]    K_LAST = 4'(COL-1);
   localparam logic [FW-1:0] FULL_L = FW'(DEPTH);

   logic [3:0]                  k_q, k_d;
   logic [ROW_W-1:0]            row_q, row_d;
   logic [DEPTH-1:0][ROW_W-1:0] mem_q, mem_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]               fill_q, fill_d;
   logic                        ovf_q, ovf_d;

   logic [ROW_W-1:0] row_now;
   logic             empty, full, complete, pop, push;

   always_comb begin
      // Partial row with this cycle's pair merged in; on a completion cycle
      // this is the row that gets pushed.
      row_now = row_q;
      if (norm_valid) begin
         row_now[int'(k_q)*BW_PSUM +: BW_PSUM]       = psum_norm_1;
         row_now[(COL+int'(k_q))*BW_PSUM +: BW_PSUM] = psum_norm_2;
      end

      empty    = (fill_q == '0);
      full     = (fill_q == FULL_L);
      // clear beats a concurrent pair, so it also cancels a completion.
      complete = norm_valid && !clear && (k_q == K_LAST);
      pop      = !empty && row_ready;
      // A pop in the same cycle frees the slot a full FIFO needs.
      push     = complete && (!full || pop);

      k_d      = k_q;
      row_d    = row_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      ovf_d    = ovf_q | (complete & ~push);

      if (clear) begin
         k_d   = '0;
         row_d = '0;
      end else if (norm_valid) begin
         if (complete) begin
            k_d   = '0;
            row_d = '0;
         end else begin
            k_d   = k_q + 4'd1;
            row_d = row_now;
         end
      end

      if (push) begin
         mem_d[wr_ptr_q] = row_now;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      case ({push, pop})
         2'b10:   fill_d = fill_q + FW'(1);
         2'b01:   fill_d = fill_q - FW'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q      <= '0;
         row_q    <= '0;
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         k_q      <= k_d;
         row_q    <= row_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ovf_q    <= ovf_d;
      end
   end

   assign row_valid  = !empty;
   assign row_out    = empty ? '0 : mem_q[rd_ptr_q];
   assign fill_level = fill_q;
   assign overflow   = ovf_q;

endmodule
